// File: rtl/kypd_pkg.sv
// Shared definitions for the keypad scanner: FSM encoding, key map and default timing.
package kypd_pkg;

  typedef enum logic [1:0] {
    S_DRIVE  = 2'd0,
    S_SAMPLE = 2'd1,
    S_EVAL   = 2'd2
  } scan_state_e;

  localparam int unsigned COL_DWELL_DEF      = 100000;
  localparam int unsigned DEBOUNCE_SCANS_DEF = 4;

  // Indexed by col*4 + row, the same layout as the scan snapshot.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  function automatic logic key_single(input logic [15:0] v);
    return (v != 16'h0000) && ((v & (v - 16'd1)) == 16'h0000);
  endfunction

  function automatic logic [3:0] key_of(input logic [15:0] v);
    logic [3:0] code;
    code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) code = KEY_MAP[i];
    end
    return code;
  endfunction

endpackage

// File: rtl/kypd_fifo.sv
// Key event storage: DEPTH-entry queue with pop-on-ack handshake and sticky overrun flag.
module kypd_fifo #(
  parameter int unsigned DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [3:0] push_data,
  input  logic       ack,
  output logic [3:0] data,
  output logic       valid,
  output logic       overrun
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             pop, wr_en, drop;

  // A pop frees a slot in the same cycle, so push-while-full-with-pop is accepted.
  always_comb begin
    pop   = ack && (count != '0);
    wr_en = push && ((count != CNT_FULL) || pop);
    drop  = push && (count == CNT_FULL) && !pop;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)   rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
      if (drop)     overrun <= 1'b1;
      else if (ack) overrun <= 1'b0;
    end
  end

  always_comb begin
    valid = (count != '0);
    data  = valid ? mem[rd_ptr] : 4'h0;
  end

endmodule

// File: rtl/kypd_scanner.sv
// 4x4 keypad scanner with frame debounce and single-key press events.
// Define KYPD_FIFO_EN for a 4-entry event FIFO; default is a single holding register.
module kypd_scanner
  import kypd_pkg::*;
#(
  parameter int unsigned COL_DWELL      = COL_DWELL_DEF,
  parameter int unsigned DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF
) (
  input  logic       OSC_100MHz,
  input  logic       RST,
  output logic [3:0] KYPD_COL,
  input  logic [3:0] KYPD_ROW,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       read_key_ack,
  output logic       overrun
);

`ifdef KYPD_FIFO_EN
  localparam int unsigned FIFO_DEPTH = 4;
`else
  localparam int unsigned FIFO_DEPTH = 1;
`endif

  localparam int unsigned DWELL_W = $clog2(COL_DWELL);
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_SCANS) + 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(COL_DWELL - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(DEBOUNCE_SCANS - 1);

  scan_state_e        state;
  logic [1:0]         col;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         col_drive;
  logic [3:0]         row_meta, row_sync;
  logic [15:0]        snapshot, prev_frame, debounced;
  logic [CNT_W-1:0]   stable_cnt, stable_nxt;
  logic               frame_eq, take, press;
  logic               push;
  logic [3:0]         push_code;

  always_comb begin
    frame_eq   = (snapshot == prev_frame);
    stable_nxt = '0;
    if (frame_eq) stable_nxt = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + 1'b1;
    take  = frame_eq && (stable_nxt == CNT_MAX);
    // Only a zero-to-one-key transition of the debounced state is a press.
    press = take && (debounced == 16'h0000) && key_single(snapshot);
  end

  always_ff @(posedge OSC_100MHz) begin
    if (!RST) begin
      state      <= S_DRIVE;
      col        <= 2'd0;
      dwell      <= '0;
      col_drive  <= 4'b1110;
      row_meta   <= 4'hF;
      row_sync   <= 4'hF;
      snapshot   <= '0;
      prev_frame <= '0;
      debounced  <= '0;
      stable_cnt <= '0;
      push       <= 1'b0;
      push_code  <= 4'h0;
    end else begin
      row_meta <= KYPD_ROW;
      row_sync <= row_meta;
      push     <= 1'b0;
      unique case (state)
        S_DRIVE: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            state <= S_SAMPLE;
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        S_SAMPLE: begin
          snapshot[{col, 2'b00} +: 4] <= ~row_sync;
          if (col == 2'd3) begin
            state <= S_EVAL;
          end else begin
            col       <= col + 2'd1;
            col_drive <= ~(4'b0001 << (col + 2'd1));
            state     <= S_DRIVE;
          end
        end
        S_EVAL: begin
          stable_cnt <= stable_nxt;
          prev_frame <= snapshot;
          if (take) debounced <= snapshot;
          push      <= press;
          push_code <= key_of(snapshot);
          col       <= 2'd0;
          col_drive <= 4'b1110;
          state     <= S_DRIVE;
        end
        default: state <= S_DRIVE;
      endcase
    end
  end

  assign KYPD_COL = col_drive;

  kypd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (OSC_100MHz),
    .rst_n    (RST),
    .push     (push),
    .push_data(push_code),
    .ack      (read_key_ack),
    .data     (key_code),
    .valid    (key_valid),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_kypd_scanner.sv
// Bench for kypd_scanner: a keypad matrix model driven by a pressed-key mask, directed checks.
module tb_kypd_scanner;

  localparam int unsigned COL_DWELL      = 4;
  localparam int unsigned DEBOUNCE_SCANS = 2;
  localparam int          FRAME          = 4 * (COL_DWELL + 1) + 1;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ack = 1'b0;
  logic [3:0]  col, row, code;
  logic        valid, ovr;
  logic [15:0] pressed = 16'h0000;
  int          errors = 0;
  int          checks = 0;
  vec_t        tbl [16];

  kypd_scanner #(
    .COL_DWELL     (COL_DWELL),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) dut (
    .OSC_100MHz  (clk),
    .RST         (rst_n),
    .KYPD_COL    (col),
    .KYPD_ROW    (row),
    .key_code    (code),
    .key_valid   (valid),
    .read_key_ack(ack),
    .overrun     (ovr)
  );

  always #5 clk = ~clk;

  // Pressed key (c, r) is bit c*4+r; it pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (col[c] == 1'b0 && pressed[c*4+r]) row[r] = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (valid !== 1'b1 && n < 12 * FRAME) begin
      tick(1);
      n++;
    end
    check({name, " key_valid"}, {3'b000, valid}, 4'h1);
  endtask

  task automatic pop();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic release_settle();
    pressed = 16'h0000;
    tick(4 * FRAME);
  endtask

  // Returns at the first cycle of the next frame (column 0 freshly driven).
  task automatic wait_frame_start();
    int n = 0;
    while (col !== 4'b0111 && n < 3 * FRAME) begin
      tick(1);
      n++;
    end
    while (col !== 4'b1110 && n < 3 * FRAME) begin
      tick(1);
      n++;
    end
    check("frame start col", col, 4'b1110);
  endtask

  task automatic press_release(input logic [15:0] k);
    pressed = k;
    tick(5 * FRAME);
    release_settle();
  endtask

  initial begin
    tbl[0]  = '{16'h0001, 4'h1};
    tbl[1]  = '{16'h0002, 4'h4};
    tbl[2]  = '{16'h0004, 4'h7};
    tbl[3]  = '{16'h0008, 4'h0};
    tbl[4]  = '{16'h0010, 4'h2};
    tbl[5]  = '{16'h0020, 4'h5};
    tbl[6]  = '{16'h0040, 4'h8};
    tbl[7]  = '{16'h0080, 4'hF};
    tbl[8]  = '{16'h0100, 4'h3};
    tbl[9]  = '{16'h0200, 4'h6};
    tbl[10] = '{16'h0400, 4'h9};
    tbl[11] = '{16'h0800, 4'hE};
    tbl[12] = '{16'h1000, 4'hA};
    tbl[13] = '{16'h2000, 4'hB};
    tbl[14] = '{16'h4000, 4'hC};
    tbl[15] = '{16'h8000, 4'hD};

    // Reset state
    tick(3);
    check("reset KYPD_COL", col, 4'b1110);
    check("reset key_code", code, 4'h0);
    check("reset key_valid", {3'b000, valid}, 4'h0);
    check("reset overrun", {3'b000, ovr}, 4'h0);
    rst_n = 1'b1;

    // Key 6 held for six frames: one event, held until ack
    pressed = 16'h0200;
    tick(6 * FRAME);
    check("hold6 key_valid", {3'b000, valid}, 4'h1);
    check("hold6 key_code", code, 4'h6);
    pop();
    check("hold6 ack key_valid", {3'b000, valid}, 4'h0);
    check("hold6 ack key_code", code, 4'h0);
    tick(3 * FRAME);
    check("hold6 single event", {3'b000, valid}, 4'h0);
    check("hold6 overrun", {3'b000, ovr}, 4'h0);
    release_settle();

    // Anti-ghosting: 5+9, then 5 alone, then release, then 5
    pressed = 16'h0420;
    tick(6 * FRAME);
    check("ghost 5+9", {3'b000, valid}, 4'h0);
    pressed = 16'h0020;
    tick(6 * FRAME);
    check("ghost 5 left", {3'b000, valid}, 4'h0);
    pressed = 16'h0000;
    tick(4 * FRAME);
    check("ghost released", {3'b000, valid}, 4'h0);
    pressed = 16'h0020;
    wait_valid("ghost press5");
    check("ghost press5 code", code, 4'h5);
    pop();
    release_settle();

    // Key 1 bouncing every frame, then held
    for (int i = 0; i < 8; i++) begin
      pressed[0] = ~pressed[0];
      tick(FRAME);
    end
    check("bounce no event", {3'b000, valid}, 4'h0);
    pressed = 16'h0001;
    wait_valid("bounce hold");
    check("bounce hold code", code, 4'h1);
    pop();
    tick(4 * FRAME);
    check("bounce single event", {3'b000, valid}, 4'h0);
    release_settle();

`ifndef KYPD_FIFO_EN
    // Holding register: second press dropped while first unread
    pressed = 16'h0001;
    wait_valid("ovr press1");
    pressed = 16'h0000;
    tick(4 * FRAME);
    pressed = 16'h0010;
    tick(6 * FRAME);
    check("ovr key_code", code, 4'h1);
    check("ovr overrun", {3'b000, ovr}, 4'h1);
    pop();
    check("ovr ack key_valid", {3'b000, valid}, 4'h0);
    check("ovr ack overrun", {3'b000, ovr}, 4'h0);
    release_settle();
`else
    begin
      logic [15:0] keys5 [5];
      logic [3:0]  exp5 [5];
      keys5 = '{16'h1000, 16'h2000, 16'h4000, 16'h8000, 16'h0008};
      exp5  = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h0};
      // Five events into four slots: last is dropped
      for (int i = 0; i < 5; i++) press_release(keys5[i]);
      check("fifo overrun", {3'b000, ovr}, 4'h1);
      for (int i = 0; i < 4; i++) begin
        check("fifo pop code", code, exp5[i]);
        pop();
        check("fifo pop overrun", {3'b000, ovr}, 4'h0);
      end
      check("fifo drained", {3'b000, valid}, 4'h0);
      // Refill, then ack exactly in the cycle the fifth event is pushed
      for (int i = 0; i < 4; i++) press_release(keys5[i]);
      wait_frame_start();
      pressed = 16'h0008;
      wait_frame_start();
      wait_frame_start();
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      check("fifo push+pop overrun", {3'b000, ovr}, 4'h0);
      for (int i = 1; i < 5; i++) begin
        check("fifo push+pop code", code, exp5[i]);
        pop();
      end
      check("fifo push+pop drained", {3'b000, valid}, 4'h0);
      release_settle();
    end
`endif

    // Reset mid-drive with key 8 held
    pressed = 16'h0040;
    wait_valid("rst pre");
    check("rst pre code", code, 4'h8);
    begin
      int n = 0;
      while (col !== 4'b1101 && n < 2 * FRAME) begin
        tick(1);
        n++;
      end
    end
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check("rst KYPD_COL", col, 4'b1110);
    check("rst key_valid", {3'b000, valid}, 4'h0);
    check("rst key_code", code, 4'h0);
    rst_n = 1'b1;
    wait_valid("rst post");
    check("rst post code", code, 4'h8);
    pop();
    tick(5 * FRAME);
    check("rst post single", {3'b000, valid}, 4'h0);
    release_settle();

    // Full key map
    for (int i = 0; i < 16; i++) begin
      pressed = tbl[i].keys;
      wait_valid("map");
      check("map code", code, tbl[i].code);
      pop();
      check("map ack key_valid", {3'b000, valid}, 4'h0);
      release_settle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
